// File: rtl/taxi_eth_mac_swap_pkg.sv
// Shared types and helpers for the loopback MAC-address swap stage.
// A beat is the AXI4-Stream payload plus the frame-start and swap-enable tags.
package taxi_eth_mac_swap_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_KEEP_W = 8;
    localparam int unsigned AXIS_ID_W   = 8;
    localparam int unsigned AXIS_USER_W = 1;

    localparam int unsigned ETH_DST_OFF = 0;
    localparam int unsigned ETH_SRC_OFF = 6;
    localparam int unsigned ETH_ALEN    = 6;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
        logic [AXIS_ID_W-1:0]   id;
        logic [AXIS_USER_W-1:0] user;
    } axis_beat_t;

    typedef struct packed {
        axis_beat_t axis;
        logic       first;
        logic       en;
    } beat_t;

    // Outgoing first beat (tags dropped) and the rewritten beat that stays held.
    typedef struct packed {
        axis_beat_t o;
        beat_t      h;
    } beat_pair_t;

    // Beat 0 takes src bytes 0-5 in its dst slots and dst bytes 0-1 in its src slots;
    // beat 1 takes dst bytes 2-5 in place of src bytes 2-5.
    function automatic beat_pair_t swap_beats(beat_t h, beat_t x);
        beat_pair_t r;
        r.o = h.axis;
        r.h = x;
        r.o.data = {h.axis.data[15:0], x.axis.data[31:0], h.axis.data[63:48]};
        r.h.axis.data = {x.axis.data[63:32], h.axis.data[47:16]};
        return r;
    endfunction

endpackage

// File: rtl/taxi_eth_mac_swap_if.sv
// AXI4-Stream bundle shared by the frame FIFO, the swap stage and the MAC TX.
interface taxi_axis_if
    import taxi_eth_mac_swap_pkg::*;
#(
    parameter int unsigned DATA_W = AXIS_DATA_W,
    parameter int unsigned KEEP_W = AXIS_KEEP_W,
    parameter int unsigned ID_W   = AXIS_ID_W,
    parameter int unsigned USER_W = AXIS_USER_W
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_mac_swap.sv
// Swaps Ethernet dst/src MAC addresses of looped-back frames ahead of the MAC TX.
// One-beat hold register H pairs beat 0 with beat 1; register O drives m_axis.
module taxi_eth_mac_swap
    import taxi_eth_mac_swap_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axis_if.slave       s_axis,
    taxi_axis_if.master      m_axis,
    input  logic             cfg_enable,
    output logic [CNT_W-1:0] stat_swapped,
    output logic [CNT_W-1:0] stat_passed,
    output logic             busy
);

    if (DATA_W != 64) begin : g_bad_data_w
        $error("taxi_eth_mac_swap: DATA_W must be 64");
    end

    beat_t      h_q;
    axis_beat_t o_q;
    logic       h_valid_q, o_valid_q;
    logic       sof_q, frame_en_q;

    beat_t      x;
    beat_pair_t pair;
    beat_t      h_nxt;
    axis_beat_t o_nxt;
    logic       o_free, s_ready, accept, xfer, do_swap;
    logic       h_valid_nxt, o_valid_nxt;

    // Handshake, transfer decision and next register contents.
    always_comb begin
        x            = '0;
        x.axis.data  = s_axis.tdata;
        x.axis.keep  = s_axis.tkeep;
        x.axis.last  = s_axis.tlast;
        x.axis.id    = s_axis.tid;
        x.axis.user  = s_axis.tuser;
        x.first      = sof_q;
        x.en         = sof_q ? cfg_enable : frame_en_q;

        o_free  = !o_valid_q || m_axis.tready;
        s_ready = !h_valid_q || o_free;
        accept  = s_axis.tvalid && s_ready;
        // A non-last beat in H only moves once its successor arrives.
        xfer    = h_valid_q && o_free && (accept || h_q.axis.last);
        do_swap = xfer && accept && h_q.first && !h_q.axis.last && h_q.en
                  && (s_axis.tkeep[3:0] == 4'hF);

        pair  = swap_beats(h_q, x);
        o_nxt = do_swap ? pair.o : h_q.axis;
        h_nxt = do_swap ? pair.h : x;

        h_valid_nxt = h_valid_q;
        if (accept)
            h_valid_nxt = 1'b1;
        else if (xfer)
            h_valid_nxt = 1'b0;

        o_valid_nxt = o_valid_q;
        if (xfer)
            o_valid_nxt = 1'b1;
        else if (m_axis.tready)
            o_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q          <= '0;
            o_q          <= '0;
            h_valid_q    <= 1'b0;
            o_valid_q    <= 1'b0;
            sof_q        <= 1'b1;
            frame_en_q   <= 1'b0;
            stat_swapped <= '0;
            stat_passed  <= '0;
            busy         <= 1'b0;
        end else begin
            h_valid_q <= h_valid_nxt;
            o_valid_q <= o_valid_nxt;
            busy      <= h_valid_nxt || o_valid_nxt;
            if (accept) begin
                h_q   <= h_nxt;
                sof_q <= s_axis.tlast;
                if (sof_q)
                    frame_en_q <= cfg_enable;
            end
            if (xfer) begin
                o_q <= o_nxt;
                if (h_q.first) begin
                    if (do_swap)
                        stat_swapped <= stat_swapped + CNT_W'(1);
                    else
                        stat_passed <= stat_passed + CNT_W'(1);
                end
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = o_valid_q;
    assign m_axis.tdata  = o_q.data;
    assign m_axis.tkeep  = o_q.keep;
    assign m_axis.tlast  = o_q.last;
    assign m_axis.tid    = o_q.id;
    assign m_axis.tuser  = o_q.user;

endmodule

// File: tb/tb_taxi_eth_mac_swap.sv
// Scoreboard bench for taxi_eth_mac_swap: frames are modelled as byte arrays whose
// first twelve bytes are exchanged when swapping is enabled and the frame is long enough.
module tb_taxi_eth_mac_swap;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic        user;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [31:0] stat_swapped, stat_passed;
    logic        busy;

    taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .ID_W(8), .USER_W(1)) s_axis ();
    taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .ID_W(8), .USER_W(1)) m_axis ();

    taxi_eth_mac_swap #(.DATA_W(64), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_axis),
        .m_axis       (m_axis),
        .cfg_enable   (cfg_enable),
        .stat_swapped (stat_swapped),
        .stat_passed  (stat_passed),
        .busy         (busy)
    );

    initial forever #4 clk = ~clk;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0, bad = 0;
    int         exp_sw = 0, exp_ps = 0;
    int         cyc = 0, out_beats = 0;
    int         tp_first = -1, tp_last = -1;
    int         rdy_mode = 1;   // 0 low, 1 high, 2 random
    logic [7:0] frm [0:127];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
        end
    end

    // Output monitor: pops one expected beat per handshake.
    initial forever begin
        @(negedge clk);
        if (!rst && m_axis.tvalid && m_axis.tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h want no beat", m_axis.tdata);
            end else begin
                mon_e = sb.pop_front();
                check("beat_data", m_axis.tdata, mon_e.data);
                check("beat_keep_last_id_user",
                      64'({m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tuser}),
                      64'({mon_e.keep, mon_e.last, mon_e.id, mon_e.user}));
            end
            out_beats++;
            if (tp_first < 0) tp_first = cyc;
            tp_last = cyc;
        end
    end

    task automatic fill_random(input bit macs);
        for (int i = 0; i < 128; i++) frm[i] = 8'($urandom);
        if (macs) begin
            for (int i = 0; i < 12; i++) frm[i] = 8'h00;
            frm[0] = 8'h02; frm[5]  = 8'h01;
            frm[6] = 8'h02; frm[11] = 8'h02;
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic [7:0] id, input logic u, input bit gaps);
        int  n;
        bit  hs;
        if (gaps)
            while ($urandom_range(0, 2) == 0) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tid    = id;
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs) begin
            @(negedge clk);
            hs = s_axis.tready;
            @(posedge clk);
            #1;
            n++;
            if (!hs && n > 2000) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got no s_tready in %0d cycles want accept", n);
                hs = 1'b1;
            end
        end
    endtask

    // Reference: swap bytes 0-5 with 6-11 when enabled and the frame has >= 12 bytes.
    task automatic send_frame(input int len, input bit en, input bit toggle, input bit gaps);
        int          nb;
        bit          swap;
        logic [7:0]  e [0:127];
        logic        usr [0:15];
        logic [7:0]  fid;
        logic [63:0] d;
        logic [7:0]  k;
        exp_t        ex;
        nb   = (len + 7) / 8;
        swap = en && (len >= 12);
        fid  = 8'($urandom);
        for (int i = 0; i < 128; i++) e[i] = frm[i];
        if (swap)
            for (int i = 0; i < 6; i++) begin
                e[i]     = frm[i + 6];
                e[i + 6] = frm[i];
            end
        if (swap) exp_sw++; else exp_ps++;
        for (int b = 0; b < nb; b++) begin
            usr[b] = 1'($urandom % 2);
            for (int i = 0; i < 8; i++) ex.data[8*i +: 8] = e[8*b + i];
            ex.last = (b == nb - 1);
            ex.keep = ex.last ? 8'((16'h1 << (len - 8*b)) - 16'h1) : 8'hFF;
            ex.id   = fid;
            ex.user = usr[b];
            sb.push_back(ex);
        end
        cfg_enable = en;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = frm[8*b + i];
            k = (b == nb - 1) ? 8'((16'h1 << (len - 8*b)) - 16'h1) : 8'hFF;
            drive_beat(d, k, b == nb - 1, fid, usr[b], gaps);
            if (b == 0 && toggle) cfg_enable = !en;
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        check({name, "_stat_swapped"}, 64'(stat_swapped), 64'(exp_sw));
        check({name, "_stat_passed"}, 64'(stat_passed), 64'(exp_ps));
    endtask

    initial begin
        logic [63:0] d;
        int          start;
        rst = 1'b1;
        cfg_enable = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata = '0;
        s_axis.tkeep = '0;
        s_axis.tlast = 1'b0;
        s_axis.tid = '0;
        s_axis.tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_m_tdata", m_axis.tdata, 64'd0);
        check("rst_m_ctl", 64'({m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tuser}), 64'd0);
        check("rst_counters", 64'({stat_swapped, stat_passed}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_tready", 64'(s_axis.tready), 64'd1);
        @(posedge clk);
        #1;

        // Directed swap and pass-through of the same 64-byte frame.
        fill_random(1'b1);
        send_frame(64, 1'b1, 1'b0, 1'b0);
        drain("swap64");
        send_frame(64, 1'b0, 1'b0, 1'b0);
        drain("pass64");
        send_frame(64, 1'b1, 1'b1, 1'b0);
        send_frame(64, 1'b0, 1'b1, 1'b1);
        drain("toggle");

        // Single-beat frame: held one cycle, then on m_axis.
        fill_random(1'b0);
        send_frame(6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("one_beat_held", 64'(m_axis.tvalid), 64'd0);
        @(negedge clk);
        check("one_beat_out", 64'(m_axis.tvalid), 64'd1);
        drain("one_beat");

        // Short second beat and the 11/12-byte boundary.
        fill_random(1'b1);
        send_frame(10, 1'b1, 1'b0, 1'b0);
        send_frame(11, 1'b1, 1'b0, 1'b0);
        send_frame(12, 1'b1, 1'b0, 1'b0);
        drain("short");

        // Back-to-back throughput.
        tp_first  = -1;
        out_beats = 0;
        start     = cyc;
        for (int f = 0; f < 100; f++) begin
            fill_random(1'b1);
            send_frame(64, 1'b1, 1'b0, 1'b0);
        end
        check("tp_accept_cycles", 64'(cyc - start), 64'd800);
        drain("throughput");
        check("tp_out_beats", 64'(out_beats), 64'd800);
        check("tp_out_span", 64'(tp_last - tp_first + 1), 64'd800);

        // Random lengths, enables, gaps and backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            fill_random($urandom_range(0, 1) == 1);
            send_frame($urandom_range(1, 72), 1'($urandom % 2), 1'($urandom % 2), 1'b1);
        end
        rdy_mode = 1;
        drain("random");

        // Reset mid-frame with beat 0 stuck in O and beat 1 in H.
        rdy_mode = 0;
        @(posedge clk);
        #2;
        fill_random(1'b1);
        cfg_enable = 1'b1;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = frm[i];
        drive_beat(d, 8'hFF, 1'b0, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) d[8*i +: 8] = frm[8 + i];
        drive_beat(d, 8'hFF, 1'b0, 8'h5A, 1'b1, 1'b0);
        s_axis.tvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_m_tvalid", 64'(m_axis.tvalid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("mid_rst_counters", 64'({stat_swapped, stat_passed}), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sw = 0;
        exp_ps = 0;
        rdy_mode = 1;
        @(posedge clk);
        #2;
        fill_random(1'b1);
        send_frame(64, 1'b1, 1'b0, 1'b0);
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
